step_pulse_gen: RTL and testbench
=================================

// Module: step_pulse_gen
// PURPOSE
//  Parametrised step-pulse source for the pedometer datapath; successor to the fixed-rate pulse generator.
//  Emits a 50%-duty square wave whose rate follows mode (walk/jog/run) or a per-second hybrid profile.
//  Adds: synchronous reset, glitch-free rate changes at period boundaries, profile end flag, step counter.
//  Sits between the mode/start controls and the step counter/display logic, beside the 1 Hz divider.
// PARAMETERS
//  CLK_HZ     100_000_000  system clock frequency; half period = CLK_HZ / (2*rate), integer floor
//  CNT_W      23           width of half-period and phase counter; must hold CLK_HZ/(2*min nonzero rate)
//  STEP_W     16           width of step_count
//  SEC_W      8            width of hybrid second index
//  PROF_LEN   144          last second of hybrid profile; profile ends when sec_index exceeds it
// PORTS
//  clk          in   1       system clock, all logic on posedge
//  rst_n        in   1       synchronous active-low reset
//  clk1hz       in   1       1 Hz square wave; asynchronous to clk; rising edge = one second tick
//  start        in   1       level, synchronous to clk; 1 = generate, 0 = stop/abort
//  mode         in   2       00 walk (32/s), 01 jog (64/s), 10 run (128/s), 11 hybrid profile
//  pulse        out  1       step pulse square wave
//  busy         out  1       1 while in RUN
//  profile_done out  1       1 once hybrid profile has run past PROF_LEN
//  step_count   out  STEP_W  pulse rising edges since last start, saturating
//  sec_index    out  SEC_W   current hybrid second, saturating at all-ones
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): pulse=0, busy=0, profile_done=0, step_count=0, sec_index=0,
//   counter=0, half=0, state=IDLE, clk1hz sync flops=0, start_q=0. Reset wins over all events.
//  States: IDLE -> RUN on start rising (start=1, start_q=0); RUN -> IDLE when start=0;
//   RUN -> DONE when mode=11 and sec_index>PROF_LEN; DONE -> IDLE when start=0. Mid-operation reset or start=0:
//   pulse=0 on that same edge, partial pulse is aborted.
//  Start edge: sec_index<=1, step_count<=0 (then +1 if pulse rises), counter<=0, half<=rate table for mode;
//   pulse<=1 on that same edge if the selected rate is nonzero -> zero-cycle latency from start sample.
//  Phase timing: counter counts 0..half-1; at half-1 pulse toggles and counter<=0.
//   pulse is high exactly half cycles and low exactly half cycles.
//  Rate changes (mode change or hybrid second change): target half recomputed combinationally every cycle;
//   loaded into half only at end of a low phase (counter=half-1, pulse=0) or when half=0.
//   Never truncates a running phase.
//  Rate 0 (hybrid sec 0 or past table): pulse held 0, counter held 0; first nonzero load starts a high phase.
//  clk1hz: 2-flop synchroniser + edge detect; one tick per rising edge.
//   In RUN with mode=11: sec_index +1, saturating at 2^SEC_W-1. Ticks ignored in IDLE/DONE and in other modes.
//  Hybrid rate by second: 1:20, 2:33, 3:66, 4:27, 5:70, 6:30, 7:19, 8:30, 9:33,
//   10-73:69, 74-79:34, 80-144:124, other:0.
//  DONE: pulse=0, busy=0, profile_done=1, held until start=0; profile_done clears on the next start edge.
//  step_count: +1 on every 0->1 transition of pulse; saturates at 2^STEP_W-1; holds value in IDLE/DONE.
//  Simultaneous tick and phase boundary: sec_index updates first;
//   the new target rate is eligible on the next boundary, not the current one.
// STRUCTURE
//  step_rate_pkg: mode encodings, WALK/JOG/RUN rate constants, state enum, function hybrid_rate(sec) -> pulses/s,
//   function half_period(rate) -> CNT_W value (0 for rate 0).
//  Sub-module half_period_timer: counter, phase toggle and boundary load of half. Top holds FSM, sync, counters.
// TESTING (bench uses CLK_HZ=1280 -> walk 20, jog 10, run 5, hybrid 20/s -> 32, 124/s -> 5)
//  mode=00, start 0->1 -> pulse high 20 clk, low 20 clk, repeating; step_count=3 after 100 clk.
//  Running jog, switch mode to 10 mid high phase -> current 10-high/10-low period completes, then 5/5.
//  mode=11, start, 1 Hz ticks -> sec1 half 32, sec2 half 19, sec3 half 9;
//   after tick 144 -> DONE, pulse=0, profile_done=1.
//  Start deasserted 3 clk into a high phase -> pulse=0 next edge, busy=0; restart clears step_count to 1.
//  rst_n=0 during RUN -> all outputs 0 next edge; clk1hz tick during IDLE leaves sec_index unchanged.
//  step_count with STEP_W=4 -> saturates at 15 after 15 rising edges; no wrap.

Source files
------------

// File: rtl/step_rate_pkg.sv
// ============================================================================
//  Module  : step_rate_pkg
//  Brief   : Mode encodings, FSM states and rate tables for step_pulse_gen.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package step_rate_pkg;

    typedef enum logic [1:0] {
        MODE_WALK   = 2'b00,
        MODE_JOG    = 2'b01,
        MODE_RUN    = 2'b10,
        MODE_HYBRID = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam int unsigned RATE_WALK = 32;
    localparam int unsigned RATE_JOG  = 64;
    localparam int unsigned RATE_RUN  = 128;

    // Hybrid rates are grouped into slots so every half period is a constant division.
    localparam int unsigned N_SLOTS = 16;
    localparam int unsigned SLOT_W  = 4;

    function automatic int unsigned slot_rate(input int unsigned slot);
        case (slot)
            32'd1:   return 20;
            32'd2:   return 33;
            32'd3:   return 66;
            32'd4:   return 27;
            32'd5:   return 70;
            32'd6:   return 30;
            32'd7:   return 19;
            32'd8:   return 69;
            32'd9:   return 34;
            32'd10:  return 124;
            default: return 0;
        endcase
    endfunction

    function automatic logic [SLOT_W-1:0] hybrid_slot(input int unsigned sec);
        if (sec >= 1 && sec <= 7)     return SLOT_W'(sec);
        else if (sec == 8)            return SLOT_W'(6);
        else if (sec == 9)            return SLOT_W'(2);
        else if (sec >= 10 && sec <= 73)  return SLOT_W'(8);
        else if (sec >= 74 && sec <= 79)  return SLOT_W'(9);
        else if (sec >= 80 && sec <= 144) return SLOT_W'(10);
        else                          return SLOT_W'(0);
    endfunction

    function automatic int unsigned hybrid_rate(input int unsigned sec);
        return slot_rate(32'(hybrid_slot(sec)));
    endfunction

    function automatic int unsigned half_period(input int unsigned clk_hz, input int unsigned rate);
        if (rate == 0) return 0;
        return clk_hz / (2 * rate);
    endfunction

endpackage

`default_nettype wire

// File: rtl/half_period_timer.sv
// ============================================================================
//  Module  : half_period_timer
//  Brief   : Phase counter and square-wave toggle; new half period taken only
//            at the end of a low phase so running phases are never truncated.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module half_period_timer #(
    parameter int unsigned CNT_W = 23
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] target_i,
    output logic             pulse_o,
    output logic             rise_o
);

    logic [CNT_W-1:0] counter_q, counter_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic             pulse_q, pulse_d;
    logic             w_last;

    assign w_last = (counter_q == half_q - CNT_W'(1));

    always_comb begin
        counter_d = counter_q;
        half_d    = half_q;
        pulse_d   = pulse_q;
        if (!en_i) begin
            counter_d = '0;
            half_d    = '0;
            pulse_d   = 1'b0;
        end else if (load_i || half_q == '0 || (w_last && !pulse_q)) begin
            // Period boundary: adopt the target; a zero rate parks the output low.
            counter_d = '0;
            half_d    = target_i;
            pulse_d   = (target_i != '0);
        end else if (w_last) begin
            counter_d = '0;
            pulse_d   = 1'b0;
        end else begin
            counter_d = counter_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            counter_q <= '0;
            half_q    <= '0;
            pulse_q   <= 1'b0;
        end else begin
            counter_q <= counter_d;
            half_q    <= half_d;
            pulse_q   <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;
    assign rise_o  = pulse_d & ~pulse_q;

endmodule

`default_nettype wire

// File: rtl/step_pulse_gen.sv
// ============================================================================
//  Module  : step_pulse_gen
//  Brief   : Mode/profile driven step-pulse source with 1 Hz profile stepping,
//            run/done FSM and saturating step counter.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module step_pulse_gen
    import step_rate_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned CNT_W    = 23,
    parameter int unsigned STEP_W   = 16,
    parameter int unsigned SEC_W    = 8,
    parameter int unsigned PROF_LEN = 144
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk1hz,
    input  logic              start,
    input  logic [1:0]        mode,
    output logic              pulse,
    output logic              busy,
    output logic              profile_done,
    output logic [STEP_W-1:0] step_count,
    output logic [SEC_W-1:0]  sec_index
);

    state_e            state_q, state_d;
    logic              start_q;
    logic [2:0]        sync_q;
    logic [SEC_W-1:0]  sec_index_q, sec_index_d;
    logic [STEP_W-1:0] step_count_q, step_count_d;
    logic              profile_done_q, profile_done_d;

    logic              w_tick;
    logic              w_start_evt;
    logic              w_hybrid;
    logic [SEC_W-1:0]  w_sec_eff;
    logic [SLOT_W-1:0] w_slot;
    logic [CNT_W-1:0]  w_target;
    logic              w_run_en;
    logic              w_rise;
    logic [CNT_W-1:0]  w_slot_half [N_SLOTS];

    assign w_tick      = sync_q[1] & ~sync_q[2];
    assign w_start_evt = (state_q == ST_IDLE) && start && !start_q;
    assign w_hybrid    = (mode_e'(mode) == MODE_HYBRID);

    // The start edge loads second 1, so the first period already uses its rate.
    assign w_sec_eff = w_start_evt ? SEC_W'(1) : sec_index_q;
    assign w_slot    = hybrid_slot(32'(w_sec_eff));

    for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_slot_half
        assign w_slot_half[gi] = CNT_W'(half_period(CLK_HZ, slot_rate(gi)));
    end

    always_comb begin
        w_target = '0;
        case (mode_e'(mode))
            MODE_WALK:   w_target = CNT_W'(half_period(CLK_HZ, RATE_WALK));
            MODE_JOG:    w_target = CNT_W'(half_period(CLK_HZ, RATE_JOG));
            MODE_RUN:    w_target = CNT_W'(half_period(CLK_HZ, RATE_RUN));
            MODE_HYBRID: w_target = w_slot_half[w_slot];
            default:     w_target = '0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        sec_index_d    = sec_index_q;
        profile_done_d = profile_done_q;
        case (state_q)
            ST_IDLE: begin
                if (w_start_evt) begin
                    state_d        = ST_RUN;
                    sec_index_d    = SEC_W'(1);
                    profile_done_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end else if (w_hybrid && 32'(sec_index_q) > PROF_LEN) begin
                    state_d        = ST_DONE;
                    profile_done_d = 1'b1;
                end else if (w_hybrid && w_tick && sec_index_q != {SEC_W{1'b1}}) begin
                    sec_index_d = sec_index_q + SEC_W'(1);
                end
            end
            ST_DONE: begin
                if (!start) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Timer is cleared on the same edge the FSM leaves RUN, aborting any partial pulse.
    assign w_run_en = (state_d == ST_RUN);

    half_period_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (w_run_en),
        .load_i   (w_start_evt),
        .target_i (w_target),
        .pulse_o  (pulse),
        .rise_o   (w_rise)
    );

    always_comb begin
        step_count_d = step_count_q;
        if (w_start_evt) begin
            step_count_d = {{(STEP_W-1){1'b0}}, w_rise};
        end else if (w_rise && step_count_q != {STEP_W{1'b1}}) begin
            step_count_d = step_count_q + STEP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            start_q        <= 1'b0;
            sync_q         <= 3'b000;
            sec_index_q    <= '0;
            step_count_q   <= '0;
            profile_done_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            start_q        <= start;
            sync_q         <= {sync_q[1:0], clk1hz};
            sec_index_q    <= sec_index_d;
            step_count_q   <= step_count_d;
            profile_done_q <= profile_done_d;
        end
    end

    assign busy         = (state_q == ST_RUN);
    assign profile_done = profile_done_q;
    assign step_count   = step_count_q;
    assign sec_index    = sec_index_q;

endmodule

`default_nettype wire

// File: tb/tb_step_pulse_gen.sv
// ============================================================================
//  Module  : tb_step_pulse_gen
//  Brief   : Self-checking bench for step_pulse_gen at CLK_HZ=1280.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_step_pulse_gen;

    typedef struct packed {
        logic        lvl;
        logic [15:0] len;
    } phase_t;

    logic        clk = 1'b0;
    logic        rst_n, clk1hz, start;
    logic [1:0]  mode;
    logic        pulse, busy, profile_done;
    logic [15:0] step_count;
    logic [7:0]  sec_index;
    logic        pulse4, busy4, profile_done4;
    logic [3:0]  step_count4;
    logic [7:0]  sec_index4;

    int          n_vec = 0;
    int          n_err = 0;
    phase_t      exp_q[$];
    logic        mon_en = 1'b0;
    logic        mon_valid = 1'b0;
    logic        mon_lvl = 1'b0;
    int          mon_len = 0;

    step_pulse_gen #(
        .CLK_HZ(1280), .CNT_W(23), .STEP_W(16), .SEC_W(8), .PROF_LEN(144)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clk1hz(clk1hz), .start(start), .mode(mode),
        .pulse(pulse), .busy(busy), .profile_done(profile_done),
        .step_count(step_count), .sec_index(sec_index)
    );

    step_pulse_gen #(
        .CLK_HZ(1280), .CNT_W(23), .STEP_W(4), .SEC_W(8), .PROF_LEN(144)
    ) dut4 (
        .clk(clk), .rst_n(rst_n), .clk1hz(clk1hz), .start(start), .mode(mode),
        .pulse(pulse4), .busy(busy4), .profile_done(profile_done4),
        .step_count(step_count4), .sec_index(sec_index4)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_phase(input logic lvl, input int len);
        exp_q.push_back('{lvl: lvl, len: 16'(len)});
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick();
        clk1hz = 1'b1;
        wait_neg(4);
        clk1hz = 1'b0;
        wait_neg(4);
    endtask

    // Measures completed pulse phases and retires them against the scoreboard.
    always @(negedge clk) begin
        if (!mon_en) begin
            mon_valid <= 1'b0;
            mon_lvl   <= pulse;
            mon_len   <= 0;
        end else if (pulse == mon_lvl) begin
            mon_len <= mon_len + 1;
        end else begin
            if (mon_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("phase_extra", 1, 0);
                end else begin
                    check_eq("phase_lvl", 32'(mon_lvl), 32'(exp_q[0].lvl));
                    check_eq("phase_len", mon_len, 32'(exp_q[0].len));
                    void'(exp_q.pop_front());
                end
            end
            mon_valid <= 1'b1;
            mon_lvl   <= pulse;
            mon_len   <= 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        mode   = 2'b00;
        clk1hz = 1'b0;
        wait_neg(3);
        check_eq("rst_pulse", pulse, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", profile_done, 0);
        check_eq("rst_steps", step_count, 0);
        check_eq("rst_sec", sec_index, 0);
        check_eq("rst_steps4", step_count4, 0);
        rst_n = 1'b1;
        wait_neg(2);

        // Walk: 20 high / 20 low
        push_phase(1, 20); push_phase(0, 20); push_phase(1, 20); push_phase(0, 20);
        mon_en = 1'b1;
        mode   = 2'b00;
        start  = 1'b1;
        wait_neg(100);
        check_eq("walk_steps", step_count, 3);
        check_eq("walk_busy", busy, 1);
        mon_en = 1'b0;
        check_eq("walk_left", exp_q.size(), 0);
        wait_neg(23);
        check_eq("abort_pre_pulse", pulse, 1);
        start = 1'b0;
        wait_neg(1);
        check_eq("abort_pulse", pulse, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_steps", step_count, 4);
        start = 1'b1;
        wait_neg(1);
        check_eq("restart_steps", step_count, 1);
        check_eq("restart_pulse", pulse, 1);
        start = 1'b0;
        wait_neg(2);

        // Jog, then run selected mid high phase
        push_phase(1, 10); push_phase(0, 10); push_phase(1, 10); push_phase(0, 10);
        push_phase(1, 5);  push_phase(0, 5);  push_phase(1, 5);  push_phase(0, 5);
        mon_en = 1'b1;
        mode   = 2'b01;
        start  = 1'b1;
        wait_neg(23);
        mode = 2'b10;
        wait_neg(40);
        mon_en = 1'b0;
        check_eq("jogrun_left", exp_q.size(), 0);
        wait_neg(153);
        check_eq("sat_steps16", step_count, 20);
        check_eq("sat_steps4", step_count4, 15);
        start = 1'b0;
        wait_neg(2);

        // Hybrid profile, second ticks placed relative to the start edge
        push_phase(1, 32); push_phase(0, 32); push_phase(1, 19); push_phase(0, 19);
        push_phase(1, 9);  push_phase(0, 9);  push_phase(1, 9);  push_phase(0, 9);
        push_phase(1, 23);
        mon_en = 1'b1;
        mode   = 2'b11;
        start  = 1'b1;
        wait_neg(10); clk1hz = 1'b1;
        wait_neg(11); clk1hz = 1'b0;
        wait_neg(49); clk1hz = 1'b1;
        wait_neg(11); clk1hz = 1'b0;
        wait_neg(37); clk1hz = 1'b1;
        wait_neg(46); clk1hz = 1'b0;
        mon_en = 1'b0;
        check_eq("hyb_left", exp_q.size(), 0);
        wait_neg(4);
        check_eq("hyb_sec4", sec_index, 4);
        for (int i = 0; i < 140; i++) tick();
        check_eq("hyb_sec144", sec_index, 144);
        check_eq("hyb_busy144", busy, 1);
        check_eq("hyb_done144", profile_done, 0);
        tick();
        check_eq("done_sec", sec_index, 145);
        check_eq("done_flag", profile_done, 1);
        check_eq("done_busy", busy, 0);
        check_eq("done_pulse", pulse, 0);
        tick();
        check_eq("done_tick_sec", sec_index, 145);
        start = 1'b0;
        wait_neg(2);
        check_eq("idle_busy", busy, 0);
        tick();
        check_eq("idle_tick_sec", sec_index, 145);
        mode  = 2'b00;
        start = 1'b1;
        wait_neg(1);
        check_eq("restart_done", profile_done, 0);
        check_eq("restart_sec", sec_index, 1);
        check_eq("restart2_steps", step_count, 1);
        check_eq("restart_busy", busy, 1);

        // Reset in the middle of a run
        wait_neg(5);
        rst_n = 1'b0;
        wait_neg(1);
        check_eq("midrst_pulse", pulse, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_steps", step_count, 0);
        check_eq("midrst_sec", sec_index, 0);
        check_eq("midrst_done", profile_done, 0);
        check_eq("midrst_pulse4", pulse4, 0);
        check_eq("midrst_busy4", busy4, 0);
        check_eq("midrst_done4", profile_done4, 0);
        check_eq("midrst_sec4", sec_index4, 0);
        rst_n = 1'b1;
        start = 1'b0;
        wait_neg(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
